// File: rtl/avalon_pio_pkg.sv
// Shared definitions for the Avalon-MM output PIO with pulse timer:
// register word addresses, the address type and the pulse timer state type.
package avalon_pio_pkg;

   typedef logic [2:0] addr_t;

   localparam addr_t ADDR_DATA      = 3'd0;
   localparam addr_t ADDR_BUSY      = 3'd1;
   localparam addr_t ADDR_PULSE_LEN = 3'd2;
   localparam addr_t ADDR_PULSE     = 3'd3;
   localparam addr_t ADDR_SET       = 3'd4;
   localparam addr_t ADDR_CLEAR     = 3'd5;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } pulse_state_e;

endpackage : avalon_pio_pkg

// File: rtl/pio_pulse_timer.sv
// Hardware pulse timer: a valid trigger ORs the mask into pulse_active and
// (re)loads the shared down-counter; when the counter runs out all active
// bits are released together on the same clock.
module pio_pulse_timer
   import avalon_pio_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int PULSE_LEN_W = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   trigger,
   input  logic [WIDTH-1:0]       mask,
   input  logic [PULSE_LEN_W-1:0] len,
   output logic [WIDTH-1:0]       pulse_active
);

   pulse_state_e           r_state;
   pulse_state_e           w_state_nxt;
   logic [PULSE_LEN_W-1:0] r_cnt;
   logic [PULSE_LEN_W-1:0] w_cnt_nxt;
   logic [WIDTH-1:0]       r_active;
   logic [WIDTH-1:0]       w_active_nxt;
   logic                   w_load;

   // A trigger with an empty mask or a zero length is ignored entirely.
   assign w_load = trigger && (mask != {WIDTH{1'b0}}) && (len != {PULSE_LEN_W{1'b0}});

   // State, counter and active-mask registers; reset aborts any pulse at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_cnt    <= {PULSE_LEN_W{1'b0}};
         r_active <= {WIDTH{1'b0}};
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_active <= w_active_nxt;
      end
   end

   // Next-state logic: load/retrigger, count down, release on the 1->0 step.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_active_nxt = r_active;
      case (r_state)
         ST_IDLE: begin
            if (w_load) begin
               w_state_nxt  = ST_ACTIVE;
               w_cnt_nxt    = len;
               w_active_nxt = r_active | mask;
            end else begin
               w_state_nxt  = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (w_load) begin
               w_state_nxt  = ST_ACTIVE;
               w_cnt_nxt    = len;
               w_active_nxt = r_active | mask;
            end else if (r_cnt == PULSE_LEN_W'(1'b1)) begin
               w_state_nxt  = ST_IDLE;
               w_cnt_nxt    = {PULSE_LEN_W{1'b0}};
               w_active_nxt = {WIDTH{1'b0}};
            end else begin
               w_cnt_nxt    = r_cnt - PULSE_LEN_W'(1'b1);
            end
         end
         default: begin
            w_state_nxt  = ST_IDLE;
            w_cnt_nxt    = {PULSE_LEN_W{1'b0}};
            w_active_nxt = {WIDTH{1'b0}};
         end
      endcase
   end

   assign pulse_active = r_active;

endmodule : pio_pulse_timer

// File: rtl/avalon_pio_out_pulse.sv
// Avalon-MM output PIO: level register with atomic SET/CLEAR and an optional
// hardware-timed inverting pulse. The pulse timer, PULSE_LEN, PULSE and BUSY
// exist only when AVALON_PIO_PULSE_EN is defined; otherwise out_port = DATA.
module avalon_pio_out_pulse
   import avalon_pio_pkg::*;
#(
   parameter int               WIDTH         = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE   = {WIDTH{1'b0}},
   parameter int               PULSE_LEN_W   = 16,
   parameter int               PULSE_DEFAULT = 1000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   addr_t            w_addr;
   logic             w_wr;
   logic [WIDTH-1:0] w_wdata;
   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] w_pulse_active;
   logic             w_unused;

   assign w_addr  = address;
   assign w_wr    = chipselect && !write_n;
   assign w_wdata = writedata[WIDTH-1:0];

   // Level register: direct write, atomic set and atomic clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data <= RESET_VALUE;
      end else if (w_wr) begin
         case (w_addr)
            ADDR_DATA:  r_data <= w_wdata;
            ADDR_SET:   r_data <= r_data | w_wdata;
            ADDR_CLEAR: r_data <= r_data & ~w_wdata;
            default:    r_data <= r_data;
         endcase
      end else begin
         r_data <= r_data;
      end
   end

`ifdef AVALON_PIO_PULSE_EN
   logic [PULSE_LEN_W-1:0] r_pulse_len;
   logic                   w_trigger;

   assign w_trigger = w_wr && (w_addr == ADDR_PULSE);

   // Pulse length register; a change only affects the next trigger.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pulse_len <= PULSE_LEN_W'(PULSE_DEFAULT);
      end else if (w_wr && (w_addr == ADDR_PULSE_LEN)) begin
         r_pulse_len <= writedata[PULSE_LEN_W-1:0];
      end else begin
         r_pulse_len <= r_pulse_len;
      end
   end

   pio_pulse_timer #(
      .WIDTH       (WIDTH),
      .PULSE_LEN_W (PULSE_LEN_W)
   ) u_pulse_timer (
      .clk          (clk),
      .reset_n      (reset_n),
      .trigger      (w_trigger),
      .mask         (w_wdata),
      .len          (r_pulse_len),
      .pulse_active (w_pulse_active)
   );

   assign w_unused = ^writedata;
`else
   assign w_pulse_active = {WIDTH{1'b0}};
   assign w_unused       = ^{writedata, 32'(PULSE_LEN_W), 32'(PULSE_DEFAULT)};
`endif

   assign out_port = r_data ^ w_pulse_active;

   // Zero-wait read mux, zero-extended; write-only and reserved words read 0.
   always_comb begin
      readdata = 32'h0000_0000;
      case (w_addr)
         ADDR_DATA:      readdata[WIDTH-1:0] = r_data;
`ifdef AVALON_PIO_PULSE_EN
         ADDR_BUSY:      readdata[WIDTH-1:0] = w_pulse_active;
         ADDR_PULSE_LEN: readdata[PULSE_LEN_W-1:0] = r_pulse_len;
`endif
         default:        readdata = 32'h0000_0000;
      endcase
   end

endmodule : avalon_pio_out_pulse
